rf_dump: RTL and testbench
==========================

# rf_dump

Debug read-out engine for the single-cycle CPU's 32×32-bit register file. On a start pulse it walks every register through one register-file read port and streams each value out over a valid/ready handshake, so a testbench or debug UART can capture a full architectural-state snapshot. It sits beside the CPU datapath and drives a spare read-address port of the register file. It never writes the register file.

## Interface
- `REG_COUNT`, default 32: number of registers walked, indices 0..REG_COUNT-1.
- `ADDR_W`, default 5: register address width.
- `DATA_W`, default 32: register data width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active high.
- `start`  in  1  begin a dump; sampled only in IDLE.
- `busy`  out  1  high from the cycle after `start` is accepted until the return to IDLE.
- `done`  out  1  one-cycle pulse after the final word is accepted.
- `rf_addr`  out  ADDR_W  read address to the register file port.
- `rf_data`  in  DATA_W  combinational read data returned for `rf_addr`.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  consumer accepts the word when `out_valid` and `out_ready` are both high.
- `out_addr`  out  ADDR_W  register index of the current word.
- `out_data`  out  DATA_W  register value of the current word.
- `out_last`  out  1  marks the final word of the dump.

## Operation
- The FSM has four states: IDLE, FETCH, SEND, DONE. An internal index `idx` is ADDR_W wide.
- IDLE:
  - On `start`=1, clear `idx` to 0 and go to FETCH.
  - `start` is ignored in every other state. There is no queuing.
- FETCH:
  - `rf_addr` = `idx`.
  - At the clock edge, register `rf_data` into `out_data` and `idx` into `out_addr`.
  - Set `out_valid`=1 and `out_last` = (`idx`==REG_COUNT-1). Go to SEND.
- SEND:
  - `out_valid`, `out_addr`, `out_data` and `out_last` are held stable until the word is accepted.
  - On acceptance, if `out_last` is set, go to DONE with `out_valid`=0.
  - Otherwise, `idx`+1 and go to FETCH with `out_valid`=0.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `rf_addr` is 0 in IDLE and DONE. It holds `idx` in FETCH and SEND.
- The register file writes on the falling edge. The captured value is the register content at the FETCH rising edge, so a write in the preceding half-cycle is visible.
- The snapshot is not atomic across registers; the CPU is expected to be halted during a dump.
- `out_ready` is ignored while `out_valid`=0.

## Timing
- Reset: every output is 0 and the FSM is in IDLE: `busy`, `done`, `rf_addr`, `out_valid`, `out_addr`, `out_data`, `out_last`.
- Latency: `start` is sampled at edge E0, FETCH occupies the following cycle, and `out_valid` rises after edge E1.
- Throughput: at most one word per 2 cycles (FETCH + SEND). Each cycle of `out_ready`=0 in SEND adds one cycle.
- Minimum dump length with `out_ready` tied high: 1 + 2·REG_COUNT + 1 cycles from `start` to the `done` pulse.
- `rst` is synchronous and has priority over every state. A reset mid-dump drops the word in flight, drives `out_valid` low on the next cycle and returns to IDLE without a `done` pulse.

## Configuration
- `RF_DUMP_CHECKSUM_EN` defined:
  - After register REG_COUNT-1 is accepted, one extra word is sent: `out_data` = XOR of all REG_COUNT data words sent, `out_addr`=0.
  - `out_last` is set only on the checksum word.
  - The checksum accumulator clears on `start` and on `rst`.
  - Minimum dump length grows by 2 cycles.
- `RF_DUMP_CHECKSUM_EN` undefined: no accumulator, and `out_last` is set on register REG_COUNT-1.

## Test plan
- Preload R[i]=0x1000_0000+i and tie `out_ready`=1, then pulse `start` -> 32 words with `out_addr`=0..31 and `out_data`=0x1000_0000+i. `out_last` is high only on index 31, and `done` pulses at cycle 66 after `start`.
- Backpressure: hold `out_ready`=0 for 5 cycles on word 3 -> `out_valid`, `out_addr`=3 and `out_data` stay stable for all 5 cycles, and word 4 does not appear until acceptance.
- Pulse `start` again at word 10 -> ignored: the sequence continues to 31 and only one `done` is produced.
- Assert `rst` for one cycle while in SEND at word 7 -> the next cycle has `out_valid`=0, `busy`=0 and all outputs 0, with no `done`. A new `start` restarts at index 0.
- With `RF_DUMP_CHECKSUM_EN` and the preload above -> a 33rd word with `out_addr`=0 and `out_data`=0x0000_0000 (the XOR of 0x1000_0000..0x1000_001F) and `out_last`=1. Register 31 has `out_last`=0.
- Write R[5]=0xDEAD_BEEF on the falling edge just before word 5's FETCH edge -> `out_data` for index 5 is 0xDEAD_BEEF.

Source files
------------

// File: rtl/rf_dump.sv
// rtl/rf_dump.sv - register-file dump engine: walks every register and streams it over valid/ready.
// Optional macro RF_DUMP_CHECKSUM_EN appends an XOR checksum word after the last register.
module rf_dump #(
  parameter int REG_COUNT = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0] rf_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] idx;
  logic              accept;

`ifdef RF_DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] acc;
  logic              csum_phase;
`endif

  assign accept  = out_valid & out_ready;
  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign rf_addr = (state == FETCH || state == SEND) ? idx : '0;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   state_nx = SEND;
      SEND:    if (accept) state_nx = out_last ? DONE : FETCH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
      acc        <= '0;
      csum_phase <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            idx <= '0;
`ifdef RF_DUMP_CHECKSUM_EN
            acc        <= '0;
            csum_phase <= 1'b0;
`endif
          end
        end
        FETCH: begin
          out_valid <= 1'b1;
`ifdef RF_DUMP_CHECKSUM_EN
          if (csum_phase) begin
            out_data <= acc;
            out_addr <= '0;
            out_last <= 1'b1;
          end else begin
            out_data <= rf_data;
            out_addr <= idx;
            out_last <= 1'b0;
          end
`else
          out_data <= rf_data;
          out_addr <= idx;
          out_last <= (idx == LAST_IDX);
`endif
        end
        SEND: begin
          if (accept) begin
            out_valid <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
            // The final register leaves idx parked and arms the checksum word instead.
            if (!csum_phase) begin
              acc <= acc ^ out_data;
              if (idx == LAST_IDX) csum_phase <= 1'b1;
              else                 idx        <= idx + 1'b1;
            end
`else
            if (!out_last) idx <= idx + 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump.sv
// tb/tb_rf_dump.sv - directed self-checking bench for rf_dump with a falling-edge register-file model.
module tb_rf_dump;

`ifdef RF_DUMP_CHECKSUM_EN
  localparam int NW    = 33;
  localparam int EXTRA = 2;
`else
  localparam int NW    = 32;
  localparam int EXTRA = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic        out_last;

  logic [31:0] rf [32];
  int total = 0;
  int bad   = 0;

  assign rf_data = rf[rf_addr];

  always #5 clk = ~clk;

  rf_dump dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},      busy,      0);
    check({tag, "_done"},      done,      0);
    check({tag, "_rf_addr"},   rf_addr,   0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_addr"},  out_addr,  0);
    check({tag, "_out_data"},  out_data,  0);
    check({tag, "_out_last"},  out_last,  0);
  endtask

  // Runs one full dump; the start cycle is cycle 1, so done is expected in cycle 66 (+2 with checksum).
  task automatic dump(input int stall_at, input int restart_at, input bit poke5);
    int cyc, nword, stall, extra_done;
    bit saw_done;
    logic [31:0] exp_d, acc;
    logic [4:0]  exp_a;
    logic        exp_l;
    cyc = 1; nword = 0; stall = 0; saw_done = 0; acc = 0; extra_done = 0;
    out_ready = 1'b1;
    start = 1'b1;
    while (cyc < 300 && !saw_done) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin
        saw_done = 1;
      end else begin
        if (poke5 && busy && !out_valid && rf_addr == 5'd5) rf[5] = 32'hDEAD_BEEF;
        if (out_valid) begin
          if (nword < 32) begin
            exp_a = nword[4:0];
            exp_d = (poke5 && nword == 5) ? 32'hDEAD_BEEF : 32'h1000_0000 + nword;
            exp_l = (NW == 32) && (nword == 31);
          end else begin
            exp_a = 5'd0;
            exp_d = acc;
            exp_l = 1'b1;
          end
          check("word_addr", out_addr, exp_a);
          check("word_data", out_data, exp_d);
          check("word_last", out_last, exp_l);
          check("word_busy", busy, 1);
          if (nword == restart_at) start = 1'b1;
          if (nword == stall_at && stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
            if (nword < 32) acc = acc ^ exp_d;
            nword++;
          end
        end else begin
          out_ready = 1'b1;
        end
      end
    end
    check("done_seen", saw_done, 1);
    check("done_cycle", cyc, 66 + EXTRA + ((stall_at >= 0) ? 5 : 0));
    check("word_count", nword, NW);
    check("done_busy", busy, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    check("single_done", extra_done, 0);
    check("idle_busy", busy, 0);
    check("idle_valid", out_valid, 0);
  endtask

  initial begin
    int n;
    int late_done;
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Plain dump, ready tied high
    dump(-1, -1, 1'b0);
    // Five cycles of backpressure on word 3
    dump(3, -1, 1'b0);
    // Start pulse during word 10 must be ignored
    dump(-1, 10, 1'b0);

    // Reset while word 7 waits in SEND
    out_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(out_valid && out_addr == 5'd7) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_word7", out_valid && out_addr == 5'd7, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("midreset");
    late_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done || busy) late_done++;
    end
    check("midreset_quiet", late_done, 0);
    dump(-1, -1, 1'b0);

    // Falling-edge write to R5 right before its FETCH edge
    dump(-1, -1, 1'b1);
    rf[5] = 32'h1000_0005;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
